// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared definitions for the 4x4 keypad scanner.
//   state_t     : scanner FSM states
//   KEY_*       : codes for the non-digit keys (digits use their own value 0..9)
//   key_lookup  : {row, col} -> key code
//   is_digit    : true for codes 0..9
//   lowest_low  : index of the lowest-numbered low row in an active-low pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Layout: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = * 0 # D
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Rows are active-low; row 0 wins when several are pressed together.
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync -- two-flop synchronizer for the asynchronous keypad rows.
// Both stages reset to all-ones (rows idle high).
//   clk   : system clock
//   reset : asynchronous, active-high
//   d     : asynchronous input
//   q     : synchronized output, two cycles behind d
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make each stage sample its pre-edge input;
  // blocking ones here would collapse the two stages into a single flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce and digit decode.
// Rotates one active-low column, freezes it when a row falls, debounces the
// press, emits a single pulse per press, then waits for a debounced release.
// Optional macro KEYPAD_FUNC_KEYS_EN adds pulses for keys A, B and C.
//   clk             : system clock
//   reset           : asynchronous, active-high
//   row_in[3:0]     : keypad rows, active-low, asynchronous
//   col_out[3:0]    : column drive, active-low, exactly one bit low
//   keyboard_en     : one-cycle pulse for a debounced digit press
//   keyboard_num    : last accepted digit (already valid during keyboard_en)
//   set_code_button : (KEYPAD_FUNC_KEYS_EN) one-cycle pulse for key A
//   confirm_button  : (KEYPAD_FUNC_KEYS_EN) one-cycle pulse for key B
//   input_button    : (KEYPAD_FUNC_KEYS_EN) one-cycle pulse for key C
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       keyboard_en,
  output logic [3:0] keyboard_num
`ifdef KEYPAD_FUNC_KEYS_EN
  ,
  output logic       set_code_button,
  output logic       confirm_button,
  output logic       input_button
`endif
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  row_sync;
  state_t      state, state_next;
  logic [15:0] div_q, div_next;
  logic [1:0]  col_q, col_next;
  logic [19:0] cnt_q, cnt_next;
  logic [3:0]  pat_q, pat_next;   // row pattern seen when the press was detected
  logic [3:0]  key_q, key_next;   // decoded key of the press in progress
  logic [3:0]  num_q, num_next;
  logic        pulse_digit;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_in),
    .q     (row_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN;
      div_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
      pat_q <= '1;
      key_q <= '0;
      num_q <= '0;
    end else begin
      state <= state_next;
      div_q <= div_next;
      col_q <= col_next;
      cnt_q <= cnt_next;
      pat_q <= pat_next;
      key_q <= key_next;
      num_q <= num_next;
    end
  end

  // NOTE: every signal gets its default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    div_next   = div_q;
    col_next   = col_q;
    cnt_next   = cnt_q;
    pat_next   = pat_q;
    key_next   = key_q;
    num_next   = num_q;

    case (state)
      SCAN: begin
        if (row_sync != 4'hF) begin
          state_next = DEBOUNCE;
          pat_next   = row_sync;
          key_next   = key_lookup(lowest_low(row_sync), col_q);
          cnt_next   = '0;
          div_next   = '0;
        end else if (div_q == DIV_LAST) begin
          div_next = '0;
          col_next = col_q + 2'd1;
        end else begin
          div_next = div_q + 16'd1;
        end
      end

      DEBOUNCE: begin
        // Any change of the row pattern (release or another row falling)
        // restarts scanning from the frozen column.
        if (row_sync != pat_q) begin
          state_next = SCAN;
          cnt_next   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_q + 20'd1;
        end
      end

      PRESSED: begin
        state_next = RELEASE_WAIT;
        if (is_digit(key_q)) num_next = key_q;
      end

      RELEASE_WAIT: begin
        if (row_sync != 4'hF) begin
          cnt_next = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_next = SCAN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_q + 20'd1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  assign col_out     = ~(4'b0001 << col_q);
  assign pulse_digit = (state == PRESSED) && is_digit(key_q);
  assign keyboard_en = pulse_digit;
  // Present the new digit during the pulse itself; the register holds it after.
  assign keyboard_num = pulse_digit ? key_q : num_q;

`ifdef KEYPAD_FUNC_KEYS_EN
  assign set_code_button = (state == PRESSED) && (key_q == KEY_A);
  assign confirm_button  = (state == PRESSED) && (key_q == KEY_B);
  assign input_button    = (state == PRESSED) && (key_q == KEY_C);
`endif

endmodule
